// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencer: cause codes, FSM states and sizing helpers.
package rst_seq_ctrl_pkg;

    localparam logic [2:0] RST_CAUSE_POR  = 3'b001;
    localparam logic [2:0] RST_CAUSE_WDG  = 3'b010;
    localparam logic [2:0] RST_CAUSE_JTAG = 3'b011;
    localparam logic [2:0] RST_CAUSE_SW   = 3'b100;

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_PERIPH = 3'd1,
        S_MEM    = 3'd2,
        S_CORE   = 3'd3,
        S_RUN    = 3'd4
    } state_e;

    // Counter width for the longer of the two delays, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w == 0) ? 1 : w;
    endfunction

    // Simultaneous sources resolve as watchdog > JTAG > software.
    function automatic logic [2:0] cause_sel(input logic wdg, input logic jtag, input logic sw);
        logic [2:0] c;
        c = RST_CAUSE_SW;
        if (wdg)       c = RST_CAUSE_WDG;
        else if (jtag) c = RST_CAUSE_JTAG;
        else if (sw)   c = RST_CAUSE_SW;
        return c;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync_ff2.sv
// Generic two-flop level synchronizer with asynchronous active-low reset to 0.
module rst_seq_ctrl_sync_ff2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// SoC reset sequencer: releases peripheral, memory and core resets in order
// after any reset source clears, and records the cause of the last reset.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYC  = 8,
    parameter int unsigned STAGE_DLY = 16
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       jtag_rst_req,
    input  logic       wdg_rst_req,
    input  logic       sw_rst_req,
    output logic       periph_rst_n,
    output logic       mem_rst_n,
    output logic       core_rst_n,
    output logic       rst_busy,
    output logic [2:0] rst_cause
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYC, STAGE_DLY);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);

    logic rst_meta_q;
    logic rst_sync_q;
    logic rst_int_n;
    logic jtag_s;
    logic req_c;

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             periph_q, periph_d;
    logic             mem_q,    mem_d;
    logic             core_q,   core_d;
    logic             busy_q,   busy_d;
    logic [2:0]       cause_q,  cause_d;

    // Board reset: asserts asynchronously, releases two clocks later.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_int_n = rst_sync_q;

    rst_seq_ctrl_sync_ff2 u_jtag_sync (
        .clk   (clk),
        .rst_n (rst_int_n),
        .d_i   (jtag_rst_req),
        .q_o   (jtag_s)
    );

    assign req_c = wdg_rst_req | jtag_s | sw_rst_req;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= S_HOLD;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            mem_q    <= 1'b0;
            core_q   <= 1'b0;
            busy_q   <= 1'b1;
            cause_q  <= RST_CAUSE_POR;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            mem_q    <= mem_d;
            core_q   <= core_d;
            busy_q   <= busy_d;
            cause_q  <= cause_d;
        end
    end

    // A request always wins over a sequencing step in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        mem_d    = mem_q;
        core_d   = core_q;
        busy_d   = busy_q;
        cause_d  = cause_q;

        if (req_c) begin
            state_d  = S_HOLD;
            cnt_d    = '0;
            periph_d = 1'b0;
            mem_d    = 1'b0;
            core_d   = 1'b0;
            busy_d   = 1'b1;
            cause_d  = cause_sel(wdg_rst_req, jtag_s, sw_rst_req);
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d  = S_PERIPH;
                        periph_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PERIPH: begin
                    if (cnt_q == STAGE_LAST) begin
                        state_d = S_MEM;
                        mem_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_MEM: begin
                    if (cnt_q == STAGE_LAST) begin
                        state_d = S_CORE;
                        core_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CORE: begin
                    busy_d  = 1'b0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign periph_rst_n = periph_q;
    assign mem_rst_n    = mem_q;
    assign core_rst_n   = core_q;
    assign rst_busy     = busy_q;
    assign rst_cause    = cause_q;

endmodule
